// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared constants and types for the shift arbiter
//
// Purpose: datapath widths, shift-type encodings (reqN_op[2:1]) and the
// response-buffer state enum used by shift_arbiter and shift_core.
package shift_arb_pkg;

  localparam int DATA_W = 32;
  localparam int NUM_W  = 8;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,   // response buffer empty
    ST_FULL = 1'b1    // response buffer holds a result
  } arb_state_e;

endpackage

// File: rtl/shift_arbiter_core.sv
// rtl/shift_arbiter_core.sv - combinational ARM barrel shifter
//
// Purpose: ARM-style shift of one operand, including the immediate-zero
// special encodings (LSR #32, ASR #32, RRX) and "carry unchanged" cases.
// Ports:
//   data      in  32  operand
//   num       in  8   shift amount
//   op        in  3   [2:1] shift type, [0] 1 = register-specified amount
//   carry_in  in  1   current C (used for pass-through and RRX)
//   result    out 32  shifted operand
//   carry_out out 1   shifter carry-out
module shift_core
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [NUM_W-1:0]  num,
  input  logic [2:0]        op,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [1:0]        sh_type;
  logic              by_reg;
  logic [5:0]        amt;      // num clamped to 32
  logic [4:0]        rot;
  logic [DATA_W:0]   lsl_w;    // bit 32 = last bit shifted out
  logic [DATA_W:0]   lsr_w;    // bit 0  = last bit shifted out
  logic [DATA_W:0]   asr_w;
  logic [DATA_W-1:0] ror_w;

  always_comb begin
    sh_type = op[2:1];
    by_reg  = op[0];
    amt     = (num > 8'd32) ? 6'd32 : num[5:0];
    rot     = num[4:0];

    // One extra bit below/above the operand captures the carry-out
    // uniformly for amounts 1..32.
    lsl_w = {1'b0, data} << amt;
    lsr_w = {data, 1'b0} >> amt;
    asr_w = $signed({data, 1'b0}) >>> amt;
    ror_w = (data >> rot) | (data << (6'd32 - 6'(rot)));

    result    = data;
    carry_out = carry_in;

    if (num == '0) begin
      // Register amount 0 and immediate LSL #0 keep the default
      // pass-through with carry unchanged.
      if (!by_reg) begin
        case (sh_type)
          SH_LSR: begin
            result    = '0;
            carry_out = data[DATA_W-1];
          end
          SH_ASR: begin
            result    = {DATA_W{data[DATA_W-1]}};
            carry_out = data[DATA_W-1];
          end
          SH_ROR: begin
            result    = {carry_in, data[DATA_W-1:1]};
            carry_out = data[0];
          end
          default: begin
          end
        endcase
      end
    end else begin
      case (sh_type)
        SH_LSL: begin
          if (num > 8'd32) begin
            result    = '0;
            carry_out = 1'b0;
          end else begin
            result    = lsl_w[DATA_W-1:0];
            carry_out = lsl_w[DATA_W];
          end
        end
        SH_LSR: begin
          if (num > 8'd32) begin
            result    = '0;
            carry_out = 1'b0;
          end else begin
            result    = lsr_w[DATA_W:1];
            carry_out = lsr_w[0];
          end
        end
        SH_ASR: begin
          result    = asr_w[DATA_W:1];
          carry_out = asr_w[0];
        end
        default: begin
          // ROR uses num[4:0]; a multiple of 32 leaves data unchanged and
          // the rotated-in top bit is the carry in every case.
          result    = ror_w;
          carry_out = ror_w[DATA_W-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one barrel shifter, C flag owner
//
// Purpose: arbitrates req0 (operand path) and req1 (load/store offset path)
// onto one shift_core, buffers one registered response, owns the C flag.
// Optional macro SHIFT_ARB_STATS_EN adds saturating per-requester grant counters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           request handshake (N = 0,1)
//   reqN_data/num/op/setc      operand, amount, shift op, update-C request
//   rsp_valid/ready            response handshake
//   rsp_id/data/carry          requester index, result, shifter carry
//   cflag                      architectural C flag
//   grant_cnt0/1               accepted-request counters (SHIFT_ARB_STATS_EN)
//   cflag_we/wd                external C flag write
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [NUM_W-1:0]  req0_num,
  input  logic [2:0]        req0_op,
  input  logic              req0_setc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [NUM_W-1:0]  req1_num,
  input  logic [2:0]        req1_op,
  input  logic              req1_setc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              cflag,
`ifdef SHIFT_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  input  logic              cflag_we,
  input  logic              cflag_wd
);

  arb_state_e        state;
  logic              last_gnt;   // requester granted most recently
  logic              rsp_setc;   // buffered response wants to update C

  logic              rsp_hs;
  logic              slot_free;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              carry_in;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_W-1:0]  sel_num;
  logic [2:0]        sel_op;
  logic              sel_setc;
  logic [DATA_W-1:0] sh_result;
  logic              sh_carry;

  assign rsp_valid = (state == ST_FULL);

  always_comb begin
    rsp_hs    = (state == ST_FULL) && rsp_ready;
    slot_free = (state == ST_IDLE) || rsp_ready;

    // On a tie, req1 wins only if req0 was granted last.
    gnt1 = req1_valid && (!req0_valid || !last_gnt);
    gnt0 = req0_valid && !gnt1;

    req0_ready = slot_free && gnt0;
    req1_ready = slot_free && gnt1;
    accept     = slot_free && (req0_valid || req1_valid);

    sel_data = gnt1 ? req1_data : req0_data;
    sel_num  = gnt1 ? req1_num  : req0_num;
    sel_op   = gnt1 ? req1_op   : req0_op;
    sel_setc = gnt1 ? req1_setc : req0_setc;

    // C-in sees this cycle's C update so a back-to-back request never
    // observes a stale flag; the same value is the next cflag.
    if (cflag_we)
      carry_in = cflag_wd;
    else if (rsp_hs && rsp_setc)
      carry_in = rsp_carry;
    else
      carry_in = cflag;
  end

  shift_core u_core (
    .data      (sel_data),
    .num       (sel_num),
    .op        (sel_op),
    .carry_in  (carry_in),
    .result    (sh_result),
    .carry_out (sh_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_gnt  <= ~FIRST_PRIO;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_setc  <= 1'b0;
      cflag     <= 1'b0;
    end else begin
      cflag <= carry_in;
      if (accept) begin
        state     <= ST_FULL;
        last_gnt  <= gnt1;
        rsp_id    <= gnt1;
        rsp_data  <= sh_result;
        rsp_carry <= sh_carry;
        rsp_setc  <= sel_setc;
      end else if (rsp_hs) begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready && grant_cnt0 != 16'hFFFF)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_valid && req1_ready && grant_cnt1 != 16'hFFFF)
        grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_setc;
  logic [31:0] req0_data;
  logic [7:0]  req0_num;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, req1_setc;
  logic [31:0] req1_data;
  logic [7:0]  req1_num;
  logic [2:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, cflag;
  logic [31:0] rsp_data;
  logic        cflag_we, cflag_wd;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        carry;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  num;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_carry;
  } vec_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  shift_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_num   (req0_num),
    .req0_op    (req0_op),
    .req0_setc  (req0_setc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_num   (req1_num),
    .req1_op    (req1_op),
    .req1_setc  (req1_setc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .cflag      (cflag),
`ifdef SHIFT_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .cflag_we   (cflag_we),
    .cflag_wd   (cflag_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] d, input logic c);
    exp_t e;
    e.id = id;
    e.data = d;
    e.carry = c;
    sb.push_back(e);
  endtask

  task automatic set_req(input int n, input logic v, input logic [31:0] d,
                         input logic [7:0] num, input logic [2:0] op, input logic setc);
    if (n == 0) begin
      req0_valid = v; req0_data = d; req0_num = num; req0_op = op; req0_setc = setc;
    end else begin
      req1_valid = v; req1_data = d; req1_num = num; req1_op = op; req1_setc = setc;
    end
  endtask

  // Compares any response handshaking this cycle, then advances past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $error("FAIL unexpected_rsp observed id=%0d data=%h expected=none", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_carry", rsp_carry, e.carry);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b001, 8'd32,  32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[1] = '{3'b001, 8'd33,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[2] = '{3'b011, 8'd32,  32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{3'b011, 8'd200, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[4] = '{3'b100, 8'd0,   32'h7000_0000, 32'h0000_0000, 1'b0};
    vecs[5] = '{3'b111, 8'd32,  32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[6] = '{3'b011, 8'd0,   32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[7] = '{3'b000, 8'd0,   32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[8] = '{3'b011, 8'd1,   32'h0000_0003, 32'h0000_0001, 1'b1};
    vecs[9] = '{3'b101, 8'd4,   32'h8000_0010, 32'hF800_0001, 1'b0};

    set_req(0, 0, '0, '0, '0, 0);
    set_req(1, 0, '0, '0, '0, 0);
    rsp_ready = 1'b1;
    cflag_we  = 1'b0;
    cflag_wd  = 1'b0;
    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_carry", rsp_carry, 0);
    chk("reset_cflag", cflag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin with both requesters always valid.
    set_req(0, 1, 32'h0000_00F0, 8'd4, 3'b011, 0);
    set_req(1, 1, 32'hF000_0001, 8'd4, 3'b001, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0));
      chk("rr_ready1", req1_ready, (i % 2 == 1));
      if (i % 2 == 0) expect_rsp(0, 32'h0000_000F, 0);
      else            expect_rsp(1, 32'h0000_0010, 1);
      tick();
    end
    set_req(0, 0, '0, '0, '0, 0);
    set_req(1, 0, '0, '0, '0, 0);
    tick();
    chk("rr_drained", sb.size(), 0);

    // Stall: response held while rsp_ready low.
    rsp_ready = 1'b0;
    set_req(0, 1, 32'h8000_0000, 8'd40, 3'b101, 0);
    #1;
    chk("stall_acc_ready0", req0_ready, 1);
    expect_rsp(0, 32'hFFFF_FFFF, 1);
    tick();
    set_req(0, 1, 32'h1111_1111, 8'd1, 3'b001, 0);
    set_req(1, 1, 32'h0000_00F8, 8'd36, 3'b111, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_data", rsp_data, 32'hFFFF_FFFF);
      chk("stall_carry", rsp_carry, 1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_ready1", req1_ready, 1);
    chk("release_ready0", req0_ready, 0);
    expect_rsp(1, 32'h8000_000F, 1);
    tick();
    set_req(0, 0, '0, '0, '0, 0);
    set_req(1, 0, '0, '0, '0, 0);
    tick();
    chk("stall_drained", sb.size(), 0);

    // setc updates C on the response handshake.
    set_req(0, 1, 32'h8000_0001, 8'd1, 3'b001, 1);
    #1;
    chk("setc_ready0", req0_ready, 1);
    expect_rsp(0, 32'h0000_0002, 1);
    tick();
    set_req(0, 0, '0, '0, '0, 0);
    #1;
    chk("setc_rsp_valid", rsp_valid, 1);
    chk("setc_cflag_before", cflag, 0);
    tick();
    chk("setc_cflag_after", cflag, 1);
    chk("setc_idle", rsp_valid, 0);

    // External write beats a setc handshake, and is forwarded into RRX.
    set_req(0, 1, 32'h8000_0001, 8'd1, 3'b001, 1);
    expect_rsp(0, 32'h0000_0002, 1);
    tick();
    set_req(0, 0, '0, '0, '0, 0);
    set_req(1, 1, 32'h0000_0003, 8'd0, 3'b110, 0);
    cflag_we = 1'b1;
    cflag_wd = 1'b0;
    #1;
    chk("extwr_ready1", req1_ready, 1);
    expect_rsp(1, 32'h0000_0001, 1);
    tick();
    cflag_we = 1'b0;
    set_req(1, 0, '0, '0, '0, 0);
    #1;
    chk("extwr_cflag", cflag, 0);
    tick();

    // Back-to-back: draining setc carry forwarded into the accepted RRX.
    set_req(0, 1, 32'h8000_0000, 8'd0, 3'b010, 1);
    #1;
    chk("b2b_ready0", req0_ready, 1);
    expect_rsp(0, 32'h0000_0000, 1);
    tick();
    set_req(0, 0, '0, '0, '0, 0);
    set_req(1, 1, 32'h0000_0002, 8'd0, 3'b110, 0);
    #1;
    chk("b2b_ready1", req1_ready, 1);
    expect_rsp(1, 32'h8000_0001, 0);
    tick();
    set_req(1, 0, '0, '0, '0, 0);
    tick();
    chk("b2b_cflag", cflag, 1);
    chk("b2b_drained", sb.size(), 0);

    // Shift boundary table, one request per cycle, C = 1 throughout.
    foreach (vecs[k]) begin
      set_req(0, 1, vecs[k].data, vecs[k].num, vecs[k].op, 0);
      #1;
      chk("tbl_ready0", req0_ready, 1);
      expect_rsp(0, vecs[k].exp_data, vecs[k].exp_carry);
      tick();
    end
    set_req(0, 0, '0, '0, '0, 0);
    tick();
    chk("tbl_drained", sb.size(), 0);

    // Reset while a response is pending discards it.
    rsp_ready = 1'b0;
    set_req(0, 1, 32'hABCD_0000, 8'd4, 3'b001, 1);
    tick();
    set_req(0, 0, '0, '0, '0, 0);
    #1;
    chk("pend_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_carry", rsp_carry, 0);
    chk("rst_cflag", cflag, 0);
`ifdef SHIFT_ARB_STATS_EN
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1, 32'h0000_0001, 8'd4, 3'b001, 0);
    set_req(1, 1, 32'h0000_0001, 8'd8, 3'b001, 0);
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    expect_rsp(0, 32'h0000_0010, 0);
    tick();
    set_req(0, 0, '0, '0, '0, 0);
    set_req(1, 0, '0, '0, '0, 0);
    tick();
    chk("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
